mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 79 +++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// 32 x 8 memory responder: clears every location after reset, then serves
// single-cycle reads and writes with error pulses and saturating access counters.
module mem_responder #(
    parameter logic [7:0]  INIT_VAL = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    typedef enum logic {INIT, READY} state_t;

    state_t     state;
    logic [4:0] ptr;
    logic [7:0] mem [0:31];

    logic       rd_ok;
    logic       wr_ok;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;

    // The sweep and requester writes share one write port; the sweep owns it during INIT.
    always_comb begin
        rd_ok     = (state == READY) && read && !write;
        wr_ok     = (state == READY) && write && !read;
        mem_we    = (state == INIT) || wr_ok;
        mem_addr  = (state == INIT) ? ptr : addr;
        mem_wdata = (state == INIT) ? INIT_VAL : data_in;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= INIT;
            ptr      <= '0;
            data_out <= '0;
            busy     <= 1'b1;
            err      <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            err <= (state == INIT) ? (read || write) : (read && write);
            case (state)
                INIT: begin
                    ptr <= ptr + 5'd1;
                    if (ptr == 5'd31) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (rd_ok) begin
                        data_out <= mem[addr];
                        if (rd_cnt != '1)
                            rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                    if (wr_ok && (wr_cnt != '1))
                        wr_cnt <= wr_cnt + CNT_W'(1);
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; a second instance with 2-bit counters
// shares the stimulus so counter saturation is reachable in a few cycles.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;

    logic [7:0]  data_out;
    logic        busy;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    logic [7:0] data_out_s;
    logic       busy_s;
    logic       err_s;
    logic [1:0] rd_cnt_s;
    logic [1:0] wr_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.INIT_VAL(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst_(rst_), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(data_out), .busy(busy), .err(err),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    mem_responder #(.INIT_VAL(8'h00), .CNT_W(2)) dut_s (
        .clk(clk), .rst_(rst_), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(data_out_s), .busy(busy_s), .err(err_s),
        .rd_cnt(rd_cnt_s), .wr_cnt(wr_cnt_s)
    );

    // Called at a negedge: holds the request across one rising edge and
    // returns at the following negedge, where outputs are sampled.
    task automatic op(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        read    = r;
        write   = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        int n;
        rst_  = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        wait_ready(n);
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL do_reset_sweep_len: got %0d edges, want 32", n);
        end
    endtask

    task automatic test_reset();
        rst_    = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (rd_cnt !== 16'd0) begin bad++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt); end
        total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_busy_access();
        int n;
        rst_ = 1'b1;
        op(1'b0, 1'b1, 5'd7, 8'h5A);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL init_write_err: got %b want 1", err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL init_busy: got %b want 1", busy); end
        total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL init_wr_cnt: got %0d want 0", wr_cnt); end
        op(1'b1, 1'b0, 5'd2, 8'h00);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL init_b2b_err: got %b want 1", err); end
        total++; if (rd_cnt !== 16'd0) begin bad++; $display("FAIL init_rd_cnt: got %0d want 0", rd_cnt); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL init_data_out: got %h want 00", data_out); end
        op(1'b0, 1'b0, 5'd0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL init_err_clear: got %b want 0", err); end
        wait_ready(n);
        total++; if (n + 3 != 32) begin bad++; $display("FAIL sweep_len: got %0d edges want 32", n + 3); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ready_busy: got %b want 0", busy); end
    endtask

    task automatic test_init_contents();
        int nbad = 0;
        for (int i = 0; i < 32; i++) begin
            op(1'b1, 1'b0, 5'(i), 8'h00);
            total++;
            if (data_out !== 8'h00) begin
                bad++;
                $display("FAIL init_contents[%0d]: got %h want 00", i, data_out);
            end
        end
        total++; if (rd_cnt !== 16'd32) begin bad++; $display("FAIL init_rd_cnt32: got %0d want 32", rd_cnt); end
        total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL init_wr_cnt_after: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_write_read();
        do_reset();
        op(1'b0, 1'b1, 5'd5, 8'hA5);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", err); end
        total++; if (wr_cnt !== 16'd1) begin bad++; $display("FAIL wr_cnt1: got %0d want 1", wr_cnt); end
        op(1'b1, 1'b0, 5'd5, 8'h00);
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL rd_addr5: got %h want a5", data_out); end
        total++; if (rd_cnt !== 16'd1) begin bad++; $display("FAIL rd_cnt1: got %0d want 1", rd_cnt); end
        total++; if (wr_cnt !== 16'd1) begin bad++; $display("FAIL wr_cnt_after_rd: got %0d want 1", wr_cnt); end
    endtask

    task automatic test_boundaries();
        op(1'b0, 1'b1, 5'd0, 8'h11);
        op(1'b0, 1'b1, 5'd31, 8'hEE);
        op(1'b1, 1'b0, 5'd0, 8'h00);
        total++; if (data_out !== 8'h11) begin bad++; $display("FAIL rd_addr0: got %h want 11", data_out); end
        op(1'b1, 1'b0, 5'd31, 8'h00);
        total++; if (data_out !== 8'hEE) begin bad++; $display("FAIL rd_addr31: got %h want ee", data_out); end
        op(1'b1, 1'b0, 5'd1, 8'h00);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rd_addr1: got %h want 00", data_out); end
        op(1'b1, 1'b0, 5'd30, 8'h00);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rd_addr30: got %h want 00", data_out); end
        op(1'b0, 1'b1, 5'd4, 8'h3C);
        op(1'b1, 1'b0, 5'd4, 8'h00);
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL raw_addr4: got %h want 3c", data_out); end
        op(1'b0, 1'b0, 5'd31, 8'h00);
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL hold_idle: got %h want 3c", data_out); end
        op(1'b0, 1'b1, 5'd31, 8'h99);
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL hold_write: got %h want 3c", data_out); end
        total++; if (rd_cnt !== 16'd6) begin bad++; $display("FAIL bnd_rd_cnt: got %0d want 6", rd_cnt); end
        total++; if (wr_cnt !== 16'd5) begin bad++; $display("FAIL bnd_wr_cnt: got %0d want 5", wr_cnt); end
    endtask

    task automatic test_collision();
        op(1'b0, 1'b1, 5'd3, 8'h42);
        op(1'b1, 1'b1, 5'd3, 8'h77);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL coll_err: got %b want 1", err); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL coll_data_hold: got %h want 3c", data_out); end
        total++; if (rd_cnt !== 16'd6) begin bad++; $display("FAIL coll_rd_cnt: got %0d want 6", rd_cnt); end
        total++; if (wr_cnt !== 16'd6) begin bad++; $display("FAIL coll_wr_cnt: got %0d want 6", wr_cnt); end
        op(1'b1, 1'b1, 5'd3, 8'h77);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL coll_b2b_err: got %b want 1", err); end
        op(1'b0, 1'b0, 5'd3, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL coll_err_clear: got %b want 0", err); end
        op(1'b1, 1'b0, 5'd3, 8'h00);
        total++; if (data_out !== 8'h42) begin bad++; $display("FAIL coll_mem_kept: got %h want 42", data_out); end
        total++; if (rd_cnt !== 16'd7) begin bad++; $display("FAIL coll_rd_after: got %0d want 7", rd_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++)
            op(1'b1, 1'b0, 5'(i), 8'h00);
        for (int i = 0; i < 4; i++)
            op(1'b0, 1'b1, 5'(i + 8), 8'(8'h90 + i));
        total++; if (rd_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_rd_cnt: got %0d want 3", rd_cnt_s); end
        total++; if (wr_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_wr_cnt: got %0d want 3", wr_cnt_s); end
        total++; if (rd_cnt !== 16'd5) begin bad++; $display("FAIL wide_rd_cnt: got %0d want 5", rd_cnt); end
        total++; if (wr_cnt !== 16'd4) begin bad++; $display("FAIL wide_wr_cnt: got %0d want 4", wr_cnt); end
        op(1'b1, 1'b0, 5'd9, 8'h00);
        total++; if (data_out !== 8'h91) begin bad++; $display("FAIL sat_rd_addr9: got %h want 91", data_out); end
        total++; if (rd_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_rd_hold: got %0d want 3", rd_cnt_s); end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL async_data_out: got %h want 00", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL async_busy: got %b want 1", busy); end
        total++; if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin bad++; $display("FAIL async_cnts: got rd=%0d wr=%0d want 0", rd_cnt, wr_cnt); end
        @(negedge clk);
        rst_ = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep10_busy: got %b want 1", busy); end
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_outs: got busy=%b err=%b want 1 0", busy, err); end
        @(negedge clk);
        rst_ = 1'b1;
        wait_ready(n);
        total++; if (n != 32) begin bad++; $display("FAIL restart_sweep_len: got %0d want 32", n); end
        op(1'b1, 1'b0, 5'd9, 8'h00);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL restart_cleared: got %h want 00", data_out); end
    endtask

    initial begin
        test_reset();
        test_busy_access();
        test_init_contents();
        test_write_read();
        test_boundaries();
        test_collision();
        test_saturation();
        test_mid_sweep_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
